// File: rtl/sequenciador_pkg.sv
// Shared types and constants for the program sequencer.
// Opcode all-ones is the HALT instruction.
package sequenciador_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    DONE
  } estado_t;

  localparam int DATA_W_DEF = 5;
  localparam int OP_W_DEF   = 4;
  localparam int DEPTH_DEF  = 8;

  // Sliced to OP_W at the use site.
  localparam logic [31:0] OP_HALT = '1;

endpackage

// File: rtl/memoria_prog_ram.sv
// Program storage: sync write, async read.
// Whole array is cleared by reset.
module memoria_prog_ram #(
  parameter int W      = 9,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sequenciador_programa.sv
// Program sequencer: plays stored operand/opcode
// pairs out over a valid/pronto handshake.
module sequenciador_programa
  import sequenciador_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_entrada,
  input  logic [OP_W-1:0]   wr_operacao,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              modo_loop,
  input  logic              abort,
  input  logic              pronto,
  output logic              valid,
  output logic [DATA_W-1:0] entrada,
  output logic [OP_W-1:0]   operacao,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              wr_err
);

  localparam int W = DATA_W + OP_W;
  localparam logic [OP_W-1:0] HALT =
    OP_HALT[OP_W-1:0];
  localparam logic [ADDR_W:0] DEPTH_L =
    (ADDR_W+1)'(DEPTH);

  estado_t           est_q, est_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              loop_q, loop_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] ent_q, ent_d;
  logic [OP_W-1:0]   op_q, op_d;

  logic          wr_ok;
  logic          hs;
  logic          is_last;
  logic          start_ok;
  logic [W-1:0]  mem_rd;

  assign wr_ok    = wr_en &&
                    (est_q == IDLE ||
                     est_q == DONE);
  assign hs       = valid_q && pronto;
  assign is_last  = {1'b0, pc_q} ==
                    (len_q - 1'b1);
  assign start_ok = start && !abort &&
                    est_q == IDLE;

  memoria_prog_ram #(
    .W      (W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (wr_addr),
    .wdata ({wr_entrada, wr_operacao}),
    .raddr (pc_q),
    .rdata (mem_rd)
  );

  always_comb begin
    est_d   = est_q;
    pc_d    = pc_q;
    len_d   = len_q;
    loop_d  = loop_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    ent_d   = ent_q;
    op_d    = op_q;
    err_d   = err_q;

    if (wr_en && !wr_ok) err_d = 1'b1;
    if (start_ok) err_d = 1'b0;

    unique case (est_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            est_d  = DONE;
            done_d = 1'b1;
          end else begin
            len_d  = (len > DEPTH_L) ?
                     DEPTH_L : len;
            loop_d = modo_loop;
            pc_d   = '0;
            est_d  = FETCH;
          end
        end
      end
      FETCH: begin
        ent_d   = mem_rd[W-1:OP_W];
        op_d    = mem_rd[OP_W-1:0];
        valid_d = 1'b1;
        est_d   = ISSUE;
      end
      ISSUE: begin
        if (hs) begin
          valid_d = 1'b0;
          if (op_q == HALT || 
              (is_last && !loop_q)) begin
            est_d  = DONE;
            done_d = 1'b1;
            pc_d   = '0;
          end else if (is_last) begin
            pc_d  = '0;
            est_d = FETCH;
          end else begin
            pc_d  = pc_q + 1'b1;
            est_d = FETCH;
          end
        end
      end
      DONE: est_d = IDLE;
      default: est_d = IDLE;
    endcase

    // Cancel wins over everything, incl. a handshake.
    if (abort) begin
      est_d   = IDLE;
      valid_d = 1'b0;
      pc_d    = '0;
      done_d  = 1'b0;
    end

    busy_d = (est_d == FETCH) ||
             (est_d == ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      est_q   <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ent_q   <= '0;
      op_q    <= '0;
    end else begin
      est_q   <= est_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ent_q   <= ent_d;
      op_q    <= op_d;
    end
  end

  assign valid    = valid_q;
  assign entrada  = ent_q;
  assign operacao = op_q;
  assign pc       = pc_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_err   = err_q;

endmodule

// File: tb/tb_sequenciador_programa.sv
// Scoreboard bench: a list model of the program
// predicts issued words; a monitor checks handshakes.
module tb_sequenciador_programa;

  localparam int DW = 5;
  localparam int OW = 4;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_entrada = '0;
  logic [OW-1:0] wr_operacao = '0;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic          modo_loop = 1'b0;
  logic          abort = 1'b0;
  logic          pronto;
  logic          valid;
  logic [DW-1:0] entrada;
  logic [OW-1:0] operacao;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic          wr_err;

  logic auto_rdy = 1'b0;
  logic fast = 1'b0;
  logic pronto_man = 1'b0;
  logic pronto_auto = 1'b0;
  assign pronto = auto_rdy ? pronto_auto
                           : pronto_man;

  sequenciador_programa dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_entrada  (wr_entrada),
    .wr_operacao (wr_operacao),
    .start       (start),
    .len         (len),
    .modo_loop   (modo_loop),
    .abort       (abort),
    .pronto      (pronto),
    .valid       (valid),
    .entrada     (entrada),
    .operacao    (operacao),
    .pc          (pc),
    .busy        (busy),
    .done        (done),
    .wr_err      (wr_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int cyc = 0;
  int c0 = 0;
  int dc0 = 0;

  logic [DW+OW-1:0] exp_q [$];
  logic [DW+OW-1:0] mem_m [D];
  logic [DW+OW-1:0] w_pop;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    pronto_auto = (exp_q.size() > 0) &&
                  (fast || $urandom_range(3) != 0);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && pronto) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_word: got %0h",
                   {entrada, operacao});
        end else begin
          w_pop = exp_q.pop_front();
          chk("word", {entrada, operacao}, w_pop);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int a,
                           input int e,
                           input int o);
    wr_en       = 1'b1;
    wr_addr     = AW'(a);
    wr_entrada  = DW'(e);
    wr_operacao = OW'(o);
    tick();
    wr_en = 1'b0;
    mem_m[a] = {DW'(e), OW'(o)};
  endtask

  // Expected words come from walking the stored list:
  // stop at HALT, at the end, or after nlp words in loop.
  task automatic launch(input int ln, input bit lp,
                        input int nlp,
                        input bit dw, input int wa,
                        input int we_, input int wo,
                        output bit exp_done);
    int l;
    int i;
    int n;
    logic [DW+OW-1:0] w;
    if (dw) begin
      wr_en       = 1'b1;
      wr_addr     = AW'(wa);
      wr_entrada  = DW'(we_);
      wr_operacao = OW'(wo);
      mem_m[wa]   = {DW'(we_), OW'(wo)};
    end
    l = (ln > D) ? D : ln;
    exp_done = 1'b0;
    i = 0;
    n = 0;
    if (l == 0) exp_done = 1'b1;
    else begin
      while (1) begin
        w = mem_m[i];
        exp_q.push_back(w);
        n++;
        if (w[OW-1:0] == '1) begin
          exp_done = 1'b1;
          break;
        end
        if (i == l - 1) begin
          if (!lp) begin
            exp_done = 1'b1;
            break;
          end
          if (n >= nlp) break;
          i = 0;
        end else i++;
      end
    end
    dc0 = done_cnt;
    start = 1'b1;
    len = (AW+1)'(ln);
    modo_loop = lp;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    c0 = cyc;
  endtask

  task automatic finish(input bit exp_done,
                        input string nm);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 300) begin
      tick();
      k++;
    end
    chk({nm, "_drain"}, exp_q.size(), 0);
    if (exp_q.size() > 0) begin
      exp_q.delete();
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    if (exp_done) begin
      k = 0;
      while (done_cnt == dc0 && k < 4) begin
        tick();
        k++;
      end
      tick();
      tick();
      chk({nm, "_done"}, done_cnt - dc0, 1);
    end else begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk({nm, "_abort_valid"}, valid, 0);
      chk({nm, "_abort_pc"}, pc, 0);
      tick();
      tick();
      chk({nm, "_abort_nodone"},
          done_cnt - dc0, 0);
    end
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_idle_valid"}, valid, 0);
  endtask

  initial begin
    bit ed;
    int k;
    for (int i = 0; i < D; i++) mem_m[i] = '0;

    #12;
    chk("rst_valid", valid, 0);
    chk("rst_out", {entrada, operacao}, 0);
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", wr_err, 0);
    rst_n = 1'b1;
    tick();

    load_word(0, 4, 1);
    load_word(1, 6, 2);
    load_word(2, 3, 3);

    // Single shot at full rate: done 2*len after start.
    auto_rdy = 1'b1;
    fast = 1'b1;
    launch(3, 0, 0, 0, 0, 0, 0, ed);
    chk("busy_after_start", busy, 1);
    finish(ed, "single");
    chk("single_done_lat", done_cyc - c0, 6);
    chk("single_pc_end", pc, 0);
    fast = 1'b0;

    // Backpressure on word 1.
    auto_rdy = 1'b0;
    pronto_man = 1'b0;
    launch(3, 0, 0, 0, 0, 0, 0, ed);
    k = 0;
    while (!valid && k < 10) begin
      tick();
      k++;
    end
    pronto_man = 1'b1;
    tick();
    pronto_man = 1'b0;
    k = 0;
    while (!valid && k < 10) begin
      tick();
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", valid, 1);
      chk("bp_word", {entrada, operacao},
          {5'd6, 4'd2});
      tick();
    end
    auto_rdy = 1'b1;
    finish(ed, "backpressure");

    launch(2, 1, 7, 0, 0, 0, 0, ed);
    finish(ed, "loop");

    load_word(1, 0, 15);
    launch(3, 0, 0, 0, 0, 0, 0, ed);
    finish(ed, "halt");

    launch(0, 0, 0, 0, 0, 0, 0, ed);
    chk("len0_done", done, 1);
    chk("len0_valid", valid, 0);
    finish(ed, "len0");

    // Largest encodable len (15) clamps to DEPTH.
    for (int i = 0; i < D; i++)
      load_word(i, $urandom_range(31),
                $urandom_range(14));
    launch(15, 0, 0, 0, 0, 0, 0, ed);
    finish(ed, "len_clamp");

    // Same-cycle write and start: new word is played.
    launch(2, 0, 0, 1, 0, 21, 9, ed);
    finish(ed, "wr_start");

    // Write while busy is dropped and flagged.
    launch(3, 0, 0, 0, 0, 0, 0, ed);
    wr_en = 1'b1;
    wr_addr = '0;
    wr_entrada = 5'd31;
    wr_operacao = 4'd7;
    tick();
    wr_en = 1'b0;
    finish(ed, "wr_busy");
    chk("wr_err_set", wr_err, 1);
    launch(3, 0, 0, 0, 0, 0, 0, ed);
    chk("wr_err_clr", wr_err, 0);
    finish(ed, "wr_unchanged");

    // Reset during ISSUE.
    auto_rdy = 1'b0;
    pronto_man = 1'b0;
    launch(3, 0, 0, 0, 0, 0, 0, ed);
    k = 0;
    while (!valid && k < 10) begin
      tick();
      k++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_out", {entrada, operacao}, 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_busy", busy, 0);
    exp_q.delete();
    for (int i = 0; i < D; i++) mem_m[i] = '0;
    #2;
    rst_n = 1'b1;
    tick();
    auto_rdy = 1'b1;
    launch(8, 0, 0, 0, 0, 0, 0, ed);
    finish(ed, "mem_cleared");

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < D; i++)
        load_word(i, $urandom_range(31),
                  $urandom_range(15));
      launch($urandom_range(15),
             1'($urandom_range(1)),
             $urandom_range(9, 1),
             0, 0, 0, 0, ed);
      finish(ed, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
